// File: rtl/mem_access_unit_if.sv
// Load/store port bundle: core request/response handshake plus the word-addressed memory bus.
// The slave modport is the access unit's view; the master modport is the core/memory side.
interface mem_access_unit_if #(
  parameter int ADDR_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_err;
  logic [31:0]       resp_rdata;
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-3:0] bus_addr;
  logic [3:0]        bus_wstrb;
  logic [31:0]       bus_wdata;
  logic              bus_ack;
  logic [31:0]       bus_rdata;

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, bus_ack, bus_rdata,
    output req_ready, resp_valid, resp_err, resp_rdata,
    output bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata
  );

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, bus_ack, bus_rdata,
    input  req_ready, resp_valid, resp_err, resp_rdata,
    input  bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// RV32I load/store unit: checks funct3/alignment, runs one word-bus transaction with a
// wait timeout, and returns a one-cycle response carrying extended load data or an error.
module mem_access_unit #(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  mem_access_unit_if.slave mif
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t            state, state_nxt;
  logic              write_p0;
  logic [2:0]        funct3_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [31:0]       wdata_p0;
  logic              err_p1;
  logic [31:0]       rdata_p1;
  logic [CNT_W-1:0]  wait_cnt;
  logic              accept, legal, in_bus;
  logic              unused_addr_bits;

  function automatic logic req_legal(input logic wr, input logic [2:0] f3, input logic [1:0] lane);
    logic code_ok, aligned;
    case (f3)
      3'd0, 3'd1, 3'd2: code_ok = 1'b1;
      3'd4, 3'd5:       code_ok = !wr;
      default:          code_ok = 1'b0;
    endcase
    case (f3[1:0])
      2'b01:   aligned = !lane[0];
      2'b10:   aligned = (lane == 2'b00);
      default: aligned = 1'b1;
    endcase
    return code_ok && aligned;
  endfunction

  function automatic logic [3:0] store_strobe(input logic [2:0] f3, input logic [1:0] lane);
    case (f3[1:0])
      2'b00:   return 4'b0001 << lane;
      2'b01:   return 4'b0011 << lane;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] w);
    case (f3[1:0])
      2'b00:   return {4{w[7:0]}};
      2'b01:   return {2{w[15:0]}};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] lane,
                                              input logic [31:0] word);
    logic [31:0]        shifted;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] ext;
    shifted = word >> {lane, 3'b000};
    b = shifted[7:0];
    h = shifted[15:0];
    case (f3)
      3'd0:    ext = 32'(b);
      3'd1:    ext = 32'(h);
      3'd4:    ext = {24'h0, shifted[7:0]};
      3'd5:    ext = {16'h0, shifted[15:0]};
      default: ext = shifted;
    endcase
    return ext;
  endfunction

  assign accept           = mif.req_valid && mif.req_ready;
  assign legal            = req_legal(mif.req_write, mif.req_funct3, mif.req_addr[1:0]);
  assign unused_addr_bits = ^mif.req_addr[31:ADDR_W];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Ack on the final allowed wait cycle still wins over the timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = legal ? BUS : RESP;
      BUS:     if (mif.bus_ack || wait_cnt == LAST) state_nxt = RESP;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          wait_cnt <= '0;
    else if (accept)                   wait_cnt <= '0;
    else if (in_bus && !mif.bus_ack)   wait_cnt <= wait_cnt + 1'b1;
  end

  // Stage p0: request captured at acceptance
  always_ff @(posedge clk) begin
    if (accept) begin
      write_p0  <= mif.req_write;
      funct3_p0 <= mif.req_funct3;
      addr_p0   <= mif.req_addr[ADDR_W-1:0];
      wdata_p0  <= mif.req_wdata;
    end
  end

  // Stage p1: response payload; a BUS cycle without ack leaves the timeout result staged
  always_ff @(posedge clk) begin
    if (accept) begin
      err_p1   <= !legal;
      rdata_p1 <= '0;
    end else if (in_bus) begin
      err_p1   <= !mif.bus_ack;
      rdata_p1 <= (mif.bus_ack && !write_p0) ? load_extend(funct3_p0, addr_p0[1:0], mif.bus_rdata)
                                             : 32'h0;
    end
  end

  assign in_bus         = (state == BUS);
  assign mif.req_ready  = (state == IDLE) && rst;
  assign mif.resp_valid = (state == RESP);
  assign mif.resp_err   = (state == RESP) && err_p1;
  assign mif.resp_rdata = (state == RESP) ? rdata_p1 : 32'h0;
  assign mif.bus_req    = in_bus;
  assign mif.bus_we     = in_bus && write_p0;
  assign mif.bus_addr   = in_bus ? addr_p0[ADDR_W-1:2] : '0;
  assign mif.bus_wstrb  = (in_bus && write_p0) ? store_strobe(funct3_p0, addr_p0[1:0]) : 4'b0000;
  assign mif.bus_wdata  = (in_bus && write_p0) ? store_lanes(funct3_p0, wdata_p0) : 32'h0;
endmodule
